// File: rtl/bus_latch_pkg.sv
// Shared types and constants for the bus latch port block.
// FSM encoding, port count and address decode helpers.
package bus_latch_pkg;

    localparam int NUM_PORTS = 4;
    localparam int OFF_W     = 2;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        WRITE    = 2'd1,
        WAIT_LOW = 2'd2
    } state_t;

    // Hit when base <= addr <= base+3, no wrap past 8'hFF.
    function automatic logic addr_hit(
        input logic [7:0] addr,
        input logic [7:0] base
    );
        logic [8:0] d;
        d = {1'b0, addr} - {1'b0, base};
        return !d[8] && (d[7:2] == 6'd0);
    endfunction

    function automatic logic [OFF_W-1:0] addr_off(
        input logic [7:0] addr,
        input logic [7:0] base
    );
        return OFF_W'(addr - base);
    endfunction

endpackage

// File: rtl/pulse_timer.sv
// Down-counter holding port 3 for PULSE_LEN cycles.
// load restarts the count; last marks the final held cycle.
module pulse_timer #(
    parameter int PULSE_LEN = 4
) (
    input  logic Clk,
    input  logic Rst,
    input  logic load,
    output logic active,
    output logic last
);

    localparam int TW = (PULSE_LEN > 0) ? $clog2(PULSE_LEN + 1) : 1;
    localparam logic [TW-1:0] LOAD_VAL = TW'(PULSE_LEN);

    logic [TW-1:0] cnt;

    // Reload on every write, otherwise count down to zero.
    always_ff @(posedge Clk) begin
        if (Rst) begin
            cnt <= '0;
        end else if (load) begin
            cnt <= LOAD_VAL;
        end else if (cnt != '0) begin
            cnt <= cnt - 1'b1;
        end
    end

    assign active = (cnt != '0);
    assign last   = (cnt == TW'(1));

endmodule

// File: rtl/bus_latch_ports.sv
// Four write-only output ports decoded from the processor bus.
// Optional write counter output enabled by BUS_LATCH_WRCNT_EN.
module bus_latch_ports
    import bus_latch_pkg::*;
#(
    parameter logic [7:0] BASE_ADDR = 8'hF0,
    parameter int         PULSE_LEN = 4
) (
    input  logic       Clk,
    input  logic       Rst,
    input  logic [7:0] DataOut_Bus,
    input  logic [7:0] Addres_Data_Bus,
    input  logic       LE,
    output logic [7:0] Port0,
    output logic [7:0] Port1,
    output logic [7:0] Port2,
    output logic [7:0] Port3,
`ifdef BUS_LATCH_WRCNT_EN
    output logic [7:0] WrCount,
`endif
    output logic       Ack
);

    localparam logic PULSE_EN = (PULSE_LEN > 0);
    localparam logic [OFF_W-1:0] P3 = OFF_W'(NUM_PORTS - 1);

    state_t           state;
    state_t           state_nxt;
    logic             cap;
    logic             wr;
    logic [7:0]       hold_data;
    logic [OFF_W-1:0] hold_off;
    logic [7:0]       ports_q [NUM_PORTS];
    logic             ack_q;
    logic             tmr_load;
    logic             tmr_active;
    logic             tmr_last;

    // State register.
    always_ff @(posedge Clk) begin
        if (Rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // One write per LE high period; misses just wait for LE low.
    always_comb begin
        state_nxt = state;
        cap       = 1'b0;
        wr        = 1'b0;
        case (state)
            IDLE: begin
                if (LE) begin
                    if (addr_hit(Addres_Data_Bus, BASE_ADDR)) begin
                        cap       = 1'b1;
                        state_nxt = WRITE;
                    end else begin
                        state_nxt = WAIT_LOW;
                    end
                end
            end
            WRITE: begin
                wr        = 1'b1;
                state_nxt = WAIT_LOW;
            end
            WAIT_LOW: begin
                if (!LE) begin
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Capture the bus so later bus changes cannot alter the write.
    always_ff @(posedge Clk) begin
        if (Rst) begin
            hold_data <= '0;
            hold_off  <= '0;
        end else if (cap) begin
            hold_data <= DataOut_Bus;
            hold_off  <= addr_off(Addres_Data_Bus, BASE_ADDR);
        end
    end

    assign tmr_load = wr && (hold_off == P3) && PULSE_EN;

    pulse_timer #(
        .PULSE_LEN (PULSE_LEN)
    ) u_pulse_timer (
        .Clk    (Clk),
        .Rst    (Rst),
        .load   (tmr_load),
        .active (tmr_active),
        .last   (tmr_last)
    );

    // Port latches; a fresh write to port 3 beats the expiry clear.
    always_ff @(posedge Clk) begin
        if (Rst) begin
            for (int i = 0; i < NUM_PORTS; i++) begin
                ports_q[i] <= '0;
            end
        end else begin
            if (tmr_active && tmr_last) begin
                ports_q[P3] <= '0;
            end
            if (wr) begin
                ports_q[hold_off] <= hold_data;
            end
        end
    end

    // Ack shows up together with the new port value.
    always_ff @(posedge Clk) begin
        if (Rst) begin
            ack_q <= 1'b0;
        end else begin
            ack_q <= wr;
        end
    end

`ifdef BUS_LATCH_WRCNT_EN
    logic [7:0] wrcnt_q;

    // Accepted-write counter, wraps naturally at 8 bits.
    always_ff @(posedge Clk) begin
        if (Rst) begin
            wrcnt_q <= '0;
        end else if (wr) begin
            wrcnt_q <= wrcnt_q + 8'd1;
        end
    end

    assign WrCount = wrcnt_q;
`endif

    assign Port0 = ports_q[0];
    assign Port1 = ports_q[1];
    assign Port2 = ports_q[2];
    assign Port3 = ports_q[3];
    assign Ack   = ack_q;

endmodule

// File: tb/tb_bus_latch_ports.sv
// Randomized and directed checks of bus_latch_ports against a
// strobe-level reference model.
module tb_bus_latch_ports;

    localparam int BASE = 'hF0;
    localparam int PL   = 4;

    logic       Clk;
    logic       Rst;
    logic [7:0] DataOut_Bus;
    logic [7:0] Addres_Data_Bus;
    logic       LE;
    logic [7:0] Port0;
    logic [7:0] Port1;
    logic [7:0] Port2;
    logic [7:0] Port3;
    logic       Ack;
`ifdef BUS_LATCH_WRCNT_EN
    logic [7:0] WrCount;
`endif

    bus_latch_ports #(
        .BASE_ADDR (8'hF0),
        .PULSE_LEN (PL)
    ) dut (
        .Clk             (Clk),
        .Rst             (Rst),
        .DataOut_Bus     (DataOut_Bus),
        .Addres_Data_Bus (Addres_Data_Bus),
        .LE              (LE),
        .Port0           (Port0),
        .Port1           (Port1),
        .Port2           (Port2),
        .Port3           (Port3),
`ifdef BUS_LATCH_WRCNT_EN
        .WrCount         (WrCount),
`endif
        .Ack             (Ack)
    );

    initial begin
        Clk = 1'b0;
        forever #5 Clk = ~Clk;
    end

    int checks   = 0;
    int failures = 0;
    int n_ack    = 0;

    // Reference model: a strobe is accepted only when the previous one
    // has been released by LE low; its write lands one edge later.
    logic [7:0] m_port [4];
    logic       m_ack;
    logic [7:0] m_cnt;
    bit         m_blk;
    int         m_blk_min;
    bit         m_pend;
    int         m_off;
    logic [7:0] m_data;
    int         m_p3;
    int         m_edge;

    task automatic chk(input string tag, input logic [7:0] got,
                       input logic [7:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%02h exp=%02h", tag, got, exp);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < 4; i++) m_port[i] = 8'h00;
        m_ack  = 1'b0;
        m_cnt  = 8'h00;
        m_blk  = 1'b0;
        m_pend = 1'b0;
        m_p3   = 0;
        m_data = 8'h00;
        m_off  = 0;
    endtask

    task automatic model_step();
        int a;
        m_edge++;
        if (Rst) begin
            model_reset();
            return;
        end
        m_ack = 1'b0;
        if (m_p3 > 0) begin
            m_p3--;
            if (m_p3 == 0) m_port[3] = 8'h00;
        end
        if (m_pend) begin
            m_port[m_off] = m_data;
            m_ack  = 1'b1;
            m_cnt  = m_cnt + 8'd1;
            m_pend = 1'b0;
            if (m_off == 3 && PL > 0) m_p3 = PL;
        end
        a = int'(Addres_Data_Bus);
        if (m_blk) begin
            if (!LE && m_edge >= m_blk_min) m_blk = 1'b0;
        end else if (LE) begin
            m_blk = 1'b1;
            if (a >= BASE && a <= BASE + 3) begin
                m_pend    = 1'b1;
                m_off     = a - BASE;
                m_data    = DataOut_Bus;
                m_blk_min = m_edge + 2;
            end else begin
                m_blk_min = m_edge + 1;
            end
        end
    endtask

    task automatic cyc(input logic rst, input logic le,
                       input logic [7:0] addr, input logic [7:0] data);
        Rst             = rst;
        LE              = le;
        Addres_Data_Bus = addr;
        DataOut_Bus     = data;
        @(posedge Clk);
        model_step();
        @(negedge Clk);
        if (Ack === 1'b1) n_ack++;
        chk("port0", Port0, m_port[0]);
        chk("port1", Port1, m_port[1]);
        chk("port2", Port2, m_port[2]);
        chk("port3", Port3, m_port[3]);
        chk("ack", {7'd0, Ack}, {7'd0, m_ack});
`ifdef BUS_LATCH_WRCNT_EN
        chk("wrcount", WrCount, m_cnt);
`endif
    endtask

    initial begin
        int hi;
        int tot;
        logic [7:0] a;
        m_edge = 0;
        model_reset();
        Rst = 1'b1;
        LE = 1'b0;
        Addres_Data_Bus = 8'h00;
        DataOut_Bus = 8'h00;
        @(negedge Clk);

        // reset state
        cyc(1, 0, 8'h00, 8'h00);
        cyc(1, 1, 8'hF0, 8'hAA);
        chk("rst_p0", Port0, 8'h00);
        chk("rst_p3", Port3, 8'h00);
        chk("rst_ack", {7'd0, Ack}, 8'h00);
        cyc(0, 0, 8'h00, 8'h00);

        // basic write
        n_ack = 0;
        cyc(0, 1, 8'hF1, 8'h5A);
        chk("basic_early", Port1, 8'h00);
        cyc(0, 0, 8'h00, 8'h00);
        chk("basic_p1", Port1, 8'h5A);
        chk("basic_ack", {7'd0, Ack}, 8'h01);
        cyc(0, 0, 8'h00, 8'h00);
        cyc(0, 0, 8'h00, 8'h00);
        chk("basic_nack", 8'(n_ack), 8'd1);
        chk("basic_p0", Port0, 8'h00);
        chk("basic_p2", Port2, 8'h00);
        chk("basic_p3", Port3, 8'h00);

        // held strobe with changing data
        n_ack = 0;
        cyc(0, 1, 8'hF0, 8'h11);
        for (int i = 0; i < 5; i++) cyc(0, 1, 8'hF0, 8'h22);
        cyc(0, 0, 8'h00, 8'h00);
        cyc(0, 0, 8'h00, 8'h00);
        chk("held_p0", Port0, 8'h11);
        chk("held_nack", 8'(n_ack), 8'd1);

        // misses
        n_ack = 0;
        for (int i = 0; i < 3; i++) cyc(0, 1, 8'hEF, 8'h33);
        cyc(0, 0, 8'h00, 8'h00);
        for (int i = 0; i < 3; i++) cyc(0, 1, 8'h04, 8'h44);
        cyc(0, 0, 8'h00, 8'h00);
        cyc(0, 0, 8'h00, 8'h00);
        chk("miss_nack", 8'(n_ack), 8'd0);
        chk("miss_p0", Port0, 8'h11);
        chk("miss_p1", Port1, 8'h5A);
        chk("miss_p2", Port2, 8'h00);
        cyc(0, 1, 8'hF2, 8'h77);
        cyc(0, 0, 8'h00, 8'h00);
        cyc(0, 0, 8'h00, 8'h00);
        chk("after_miss_p2", Port2, 8'h77);
        chk("after_miss_nack", 8'(n_ack), 8'd1);

        // pulse port length
        hi = 0;
        cyc(0, 1, 8'hF3, 8'hFF);
        for (int i = 0; i < 8; i++) begin
            cyc(0, 0, 8'h00, 8'h00);
            if (Port3 == 8'hFF) hi++;
        end
        chk("p3_len", 8'(hi), 8'd4);
        chk("p3_clear", Port3, 8'h00);

        // pulse port rewrite while active
        tot = 0;
        cyc(0, 1, 8'hF3, 8'hFF);
        cyc(0, 0, 8'h00, 8'h00);
        if (Port3 == 8'hFF) tot++;
        cyc(0, 0, 8'h00, 8'h00);
        if (Port3 == 8'hFF) tot++;
        cyc(0, 1, 8'hF3, 8'hFF);
        if (Port3 == 8'hFF) tot++;
        hi = 0;
        for (int i = 0; i < 8; i++) begin
            cyc(0, 0, 8'h00, 8'h00);
            if (Port3 == 8'hFF) hi++;
        end
        chk("p3_rewrite_len", 8'(hi), 8'd4);
        chk("p3_total", 8'(tot + hi), 8'd7);

        // zero write to port 3 is still acknowledged
        n_ack = 0;
        cyc(0, 1, 8'hF3, 8'h00);
        cyc(0, 0, 8'h00, 8'h00);
        cyc(0, 0, 8'h00, 8'h00);
        chk("p3_zero_nack", 8'(n_ack), 8'd1);

        // reset during WRITE, LE held across release
        n_ack = 0;
        cyc(0, 1, 8'hF0, 8'h99);
        cyc(1, 1, 8'hF0, 8'h99);
        chk("rstw_ack", {7'd0, Ack}, 8'h00);
        chk("rstw_p0", Port0, 8'h00);
        chk("rstw_p1", Port1, 8'h00);
        chk("rstw_p2", Port2, 8'h00);
        cyc(0, 1, 8'hF0, 8'h99);
        cyc(0, 1, 8'hF0, 8'h99);
        chk("rstw_redo_p0", Port0, 8'h99);
        chk("rstw_redo_ack", {7'd0, Ack}, 8'h01);
        cyc(0, 0, 8'h00, 8'h00);

`ifdef BUS_LATCH_WRCNT_EN
        // counter wrap and misses
        cyc(1, 0, 8'h00, 8'h00);
        for (int i = 0; i < 257; i++) begin
            cyc(0, 1, 8'hF1, 8'(i));
            cyc(0, 0, 8'h00, 8'h00);
            cyc(0, 0, 8'h00, 8'h00);
        end
        chk("cnt_257", WrCount, 8'd1);
        cyc(0, 1, 8'hEE, 8'h00);
        cyc(0, 0, 8'h00, 8'h00);
        cyc(0, 1, 8'hF4, 8'h00);
        cyc(0, 0, 8'h00, 8'h00);
        chk("cnt_miss", WrCount, 8'd1);
`endif

        // random traffic
        for (int i = 0; i < 1500; i++) begin
            int sel;
            sel = $urandom_range(0, 6);
            if (sel < 4) a = 8'(BASE + sel);
            else if (sel == 4) a = 8'hEF;
            else if (sel == 5) a = 8'hF4;
            else a = 8'($urandom);
            cyc(($urandom_range(0, 63) == 0), $urandom_range(0, 1) == 1,
                a, 8'($urandom));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/bus_latch_ports.md
BUS_LATCH_PORTS -- requirements
Module: bus_latch_ports

Interface
REQ-001 The block SHALL have parameter BASE_ADDR, default 8'hF0, the address of port 0; ports 0..3 occupy BASE_ADDR..BASE_ADDR+3.
REQ-002 The block SHALL have parameter PULSE_LEN, default 4, the number of cycles port 3 holds a written value; 0 disables auto-clear.
REQ-003 The block SHALL have port Clk, input, 1 bit, the single clock; all logic is on its rising edge.
REQ-004 The block SHALL have port Rst, input, 1 bit, a synchronous, active-high reset.
REQ-005 The block SHALL have port DataOut_Bus, input, 8 bits, the write data driven by the processor output stage.
REQ-006 The block SHALL have port Addres_Data_Bus, input, 8 bits, the write address driven by the processor output stage.
REQ-007 The block SHALL have port LE, input, 1 bit, the write strobe; it is level-high and may stay high for many cycles.
REQ-008 The block SHALL have ports Port0, Port1, Port2 and Port3, each an output of 8 bits holding the latched port values.
REQ-009 The block SHALL have port Ack, output, 1 bit, a one-cycle pulse marking each accepted write.

Function
REQ-010 The FSM SHALL have exactly three states: IDLE, WRITE and WAIT_LOW.
REQ-011 In IDLE with LE=1, the block SHALL check for an address hit, which is Addres_Data_Bus in BASE_ADDR..BASE_ADDR+3 with the address compared as 8-bit unsigned and no wrap past 8'hFF.
- On a hit, the block SHALL capture data and the address offset (bits [1:0] of address-BASE_ADDR) into holding registers and go to WRITE.
- On a miss, the block SHALL go to WAIT_LOW with no write.
REQ-012 In WRITE, the block SHALL load Port[offset] from the holding data register, pulse Ack=1 for that one cycle and go to WAIT_LOW.
REQ-013 In WAIT_LOW, the block SHALL stay while LE=1 and return to IDLE on LE=0, so each LE high period yields at most one write.
REQ-014 Latency SHALL be as follows: with LE sampled high at edge N, the new Port value and Ack=1 are both visible after edge N+1.
REQ-015 Changes on DataOut_Bus or Addres_Data_Bus after capture SHALL NOT affect the write in progress.
REQ-016 When LE drops during WRITE, the write SHALL still complete and the FSM SHALL then return to IDLE via WAIT_LOW.
REQ-017 When PULSE_LEN>0 and port 3 is written, Port3 SHALL hold the data for exactly PULSE_LEN cycles and then clear to 0.
- A timer counts down to enforce this.
- A rewrite while the timer is active SHALL reload the data and restart the timer.
REQ-018 When PULSE_LEN=0, Port3 SHALL latch like ports 0..2.
REQ-019 Writing the value 0 to port 3 SHALL still be an accepted write, with Ack asserted and the timer restarted.
REQ-020 Ports not addressed SHALL hold their values.

Reset
REQ-021 When Rst=1 at a clock edge, the block SHALL set Port0..Port3=0, Ack=0, the pulse timer=0, the holding registers=0 and state=IDLE, overriding all other inputs.
REQ-022 If reset occurs mid-operation (WRITE or WAIT_LOW), the pending write SHALL be discarded.
REQ-023 If LE is still high on the first cycle after reset, it SHALL be treated as a new strobe from IDLE.

Configuration
REQ-024 When macro BUS_LATCH_WRCNT_EN is defined, the block SHALL add output WrCount, 8 bits.
- WrCount SHALL reset to 0.
- WrCount SHALL increment in the same cycle Ack is asserted.
- WrCount SHALL wrap from 255 to 0.
REQ-025 When BUS_LATCH_WRCNT_EN is undefined, the WrCount port and counter logic SHALL be absent and behaviour SHALL otherwise be identical.

Structure
REQ-026 Package bus_latch_pkg SHALL hold the state encoding (IDLE, WRITE, WAIT_LOW), the NUM_PORTS=4 constant and the port-offset width constant (2).
REQ-027 The port 3 countdown SHALL live in one sub-module, pulse_timer, with load, count-down and an active output, sized from PULSE_LEN.

Verification
REQ-028 Bench SHALL check a basic write: LE high 1 cycle, addr 8'hF1, data 8'h5A -> Port1=8'h5A two edges later, Ack high exactly 1 cycle, other ports stay 0.
REQ-029 Bench SHALL check a held strobe: LE high 6 cycles, addr 8'hF0, data changing 8'h11 then 8'h22 after cycle 1 -> Port0=8'h11, exactly one Ack pulse.
REQ-030 Bench SHALL check a miss: LE high, addr 8'hEF and 8'h04 -> no Ack and all ports unchanged; then LE low and a write to 8'hF2 succeeds.
REQ-031 Bench SHALL check the pulse port: PULSE_LEN=4, write 8'hFF to 8'hF3 -> Port3=8'hFF for 4 cycles then 0; a rewrite at cycle 2 extends it to 4 cycles from the rewrite.
REQ-032 Bench SHALL check reset: Rst asserted during WRITE -> no Ack and all ports 0; with LE still high after Rst release, the write re-executes.
REQ-033 Bench SHALL check the counter under BUS_LATCH_WRCNT_EN: 257 accepted writes -> WrCount=1, and misses SHALL NOT increment it.
